// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller and the PC / IF-ID stages.
package branch_redirect_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns the ID-stage branch/jump decision into PC-source select, redirect target and
// IF/ID squash, honouring hazard stalls and the delay-slot model; keeps branch statistics.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DELAY_SLOT = 1,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ID_branch_instr,
  input  logic              branch_out,
  input  logic              jump_instr,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic              stall,
  output logic              pc_src,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_if,
  output logic              busy,
  output logic              ds_branch_err,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic SQUASH_ON_TAKEN = (DELAY_SLOT == 0);
  localparam logic CHECK_DS        = (DELAY_SLOT != 0);

  state_t state;
  logic   ctrl_xfer;
  logic   decide;
  logic   taken;
  logic   ds_hit;

  // A jump wins over a simultaneous conditional branch, so jump alone forces taken.
  always_comb begin
    ctrl_xfer = ID_branch_instr | jump_instr;
    taken     = jump_instr | (ID_branch_instr & branch_out);
    decide    = (state == ST_IDLE) && !stall && ctrl_xfer;
    ds_hit    = CHECK_DS && (state == ST_REDIRECT) && ctrl_xfer;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      pc_src        <= 1'b0;
      flush_if      <= 1'b0;
      busy          <= 1'b0;
      pc_target     <= '0;
      ds_branch_err <= 1'b0;
    end else begin
      if (ds_hit) begin
        ds_branch_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (decide && taken) begin
            state     <= ST_REDIRECT;
            pc_target <= target_addr;
            pc_src    <= 1'b1;
            busy      <= 1'b1;
            flush_if  <= SQUASH_ON_TAKEN;
          end
        end
        ST_REDIRECT: begin
          // Outputs hold while stalled so the PC/IF-ID registers see them once unfrozen.
          if (!stall) begin
            state    <= ST_IDLE;
            pc_src   <= 1'b0;
            busy     <= 1'b0;
            flush_if <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          pc_src   <= 1'b0;
          busy     <= 1'b0;
          flush_if <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (decide),
    .clear   (1'b0),
    .count   (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (decide & taken),
    .clear   (1'b0),
    .count   (taken_cnt)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench: two builds (delay-slot/16-bit and squash/4-bit) share stimulus.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ID_branch_instr, branch_out, jump_instr, stall;
  logic [31:0] target_addr;

  logic        a_pc_src, a_flush_if, a_busy, a_err;
  logic [31:0] a_pc_target;
  logic [15:0] a_bcnt, a_tcnt;
  logic        b_pc_src, b_flush_if, b_busy, b_err;
  logic [31:0] b_pc_target;
  logic [3:0]  b_bcnt, b_tcnt;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.ADDR_W(32), .DELAY_SLOT(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .ID_branch_instr(ID_branch_instr),
    .branch_out(branch_out), .jump_instr(jump_instr), .target_addr(target_addr),
    .stall(stall), .pc_src(a_pc_src), .pc_target(a_pc_target), .flush_if(a_flush_if),
    .busy(a_busy), .ds_branch_err(a_err), .branch_cnt(a_bcnt), .taken_cnt(a_tcnt)
  );

  branch_redirect_ctrl #(.ADDR_W(32), .DELAY_SLOT(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .ID_branch_instr(ID_branch_instr),
    .branch_out(branch_out), .jump_instr(jump_instr), .target_addr(target_addr),
    .stall(stall), .pc_src(b_pc_src), .pc_target(b_pc_target), .flush_if(b_flush_if),
    .busy(b_busy), .ds_branch_err(b_err), .branch_cnt(b_bcnt), .taken_cnt(b_tcnt)
  );

  typedef struct {
    logic        ps;
    logic [31:0] tgt;
    logic        err_a;
    logic [15:0] bc;
    logic [15:0] tc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  event smp;

  logic        e_err;
  logic [15:0] e_bc, e_tc;

  function automatic logic [31:0] sat15(input logic [15:0] v);
    return (v > 16'd15) ? 32'd15 : {16'd0, v};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per sample point, popped after each edge or on demand.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or smp);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("a_pc_src",    {31'd0, a_pc_src},   {31'd0, e.ps});
        chk("a_busy",      {31'd0, a_busy},     {31'd0, e.ps});
        chk("a_flush_if",  {31'd0, a_flush_if}, 32'd0);
        chk("a_pc_target", a_pc_target,         e.tgt);
        chk("a_ds_err",    {31'd0, a_err},      {31'd0, e.err_a});
        chk("a_branch_cnt",{16'd0, a_bcnt},     {16'd0, e.bc});
        chk("a_taken_cnt", {16'd0, a_tcnt},     {16'd0, e.tc});
        chk("b_pc_src",    {31'd0, b_pc_src},   {31'd0, e.ps});
        chk("b_busy",      {31'd0, b_busy},     {31'd0, e.ps});
        chk("b_flush_if",  {31'd0, b_flush_if}, {31'd0, e.ps});
        chk("b_pc_target", b_pc_target,         e.tgt);
        chk("b_ds_err",    {31'd0, b_err},      32'd0);
        chk("b_branch_cnt",{28'd0, b_bcnt},     sat15(e.bc));
        chk("b_taken_cnt", {28'd0, b_tcnt},     sat15(e.tc));
      end
    end
  end

  task automatic push_exp(input logic ps, input logic [31:0] tgt);
    exp_t e;
    e.ps = ps; e.tgt = tgt; e.err_a = e_err; e.bc = e_bc; e.tc = e_tc;
    q.push_back(e);
  endtask

  // Drive one cycle of inputs; expectation describes outputs right after the next edge.
  task automatic step(input logic br, input logic bo, input logic jmp, input logic st,
                      input logic [31:0] t, input logic ps, input logic [31:0] etgt);
    ID_branch_instr = br;
    branch_out      = bo;
    jump_instr      = jmp;
    stall           = st;
    target_addr     = t;
    push_exp(ps, etgt);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    ID_branch_instr = 1'b0; branch_out = 1'b0; jump_instr = 1'b0; stall = 1'b0;
    target_addr = '0;
    e_err = 1'b0; e_bc = '0; e_tc = '0;

    #3;
    push_exp(1'b0, 32'h0);
    ->smp;
    @(posedge clk); #2;
    reset_n = 1'b1;

    step(0, 0, 0, 0, 32'h0, 0, 32'h0);

    // Taken branch, no stall: one-cycle redirect
    e_bc = 1; e_tc = 1;
    step(1, 1, 0, 0, 32'h40, 1, 32'h40);
    step(0, 0, 0, 0, 32'h0,  0, 32'h40);

    // Not-taken branch: counted, no redirect, target untouched
    e_bc = 2;
    step(1, 0, 0, 0, 32'h80, 0, 32'h40);

    // Stalled branch with branch_out toggling; decided on the unstalled cycle
    step(1, 0, 0, 1, 32'h100, 0, 32'h40);
    step(1, 1, 0, 1, 32'h100, 0, 32'h40);
    e_bc = 3; e_tc = 2;
    step(1, 1, 0, 0, 32'h100, 1, 32'h100);
    // Three stall cycles in REDIRECT, target_addr changes ignored
    step(0, 0, 0, 1, 32'hdead, 1, 32'h100);
    step(0, 0, 0, 1, 32'hdead, 1, 32'h100);
    step(0, 0, 0, 1, 32'hdead, 1, 32'h100);
    step(0, 0, 0, 0, 32'hdead, 0, 32'h100);

    // Jump followed by a branch in the delay slot / wrong-path slot
    e_bc = 4; e_tc = 3;
    step(0, 0, 1, 0, 32'h200, 1, 32'h200);
    e_err = 1'b1;
    step(1, 1, 0, 0, 32'h300, 0, 32'h200);
    step(0, 0, 0, 0, 32'h0,   0, 32'h200);

    // Branch and jump together behave as a jump even with branch_out=0
    e_bc = 5; e_tc = 4;
    step(1, 0, 1, 0, 32'h400, 1, 32'h400);
    step(0, 0, 0, 0, 32'h0,   0, 32'h400);

    // 19 taken branches: 4-bit build pins at 15, 16-bit build keeps counting
    for (int i = 0; i < 19; i++) begin
      e_bc = e_bc + 16'd1;
      e_tc = e_tc + 16'd1;
      step(1, 1, 0, 0, 32'h1000 + 32'(4 * i), 1, 32'h1000 + 32'(4 * i));
      step(0, 0, 0, 0, 32'h0,                 0, 32'h1000 + 32'(4 * i));
    end

    // Reset asserted mid-REDIRECT: outputs clear before the next edge
    e_bc = 25; e_tc = 24;
    step(0, 0, 1, 0, 32'h500, 1, 32'h500);
    reset_n = 1'b0;
    e_err = 1'b0; e_bc = '0; e_tc = '0;
    push_exp(1'b0, 32'h0);
    ->smp;
    #2;
    step(0, 0, 0, 0, 32'h0, 0, 32'h0);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 32'h0, 0, 32'h0);
    e_bc = 1; e_tc = 1;
    step(1, 1, 0, 0, 32'h60, 1, 32'h60);
    step(0, 0, 0, 0, 32'h0,  0, 32'h60);

    @(posedge clk); #2;
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Consumes the per-branch taken/not-taken decision made in ID and turns it into pipeline control: PC-source select, redirect target, and IF/ID squash.
Sits between the ID-stage condition logic and the PC/IF-ID registers.
Honours hazard-unit stalls and the MIPS delay-slot model.
Keeps saturating branch statistics for the verification and performance benches.

Parameters:
ADDR_W, 32, width of PC and target addresses
DELAY_SLOT, 1, 1 = architectural delay slot executes (no squash); 0 = squash the IF instruction on taken
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
ID_branch_instr  input  1  conditional branch present in ID this cycle
branch_out  input  1  condition result for the ID branch (1 = taken)
jump_instr  input  1  unconditional jump present in ID (always taken)
target_addr  input  ADDR_W  computed branch/jump target, valid with ID_branch_instr|jump_instr
stall  input  1  hazard unit freezing PC and IF/ID this cycle
pc_src  output  1  1 = next PC comes from pc_target
pc_target  output  ADDR_W  latched redirect target
flush_if  output  1  squash IF/ID register contents
busy  output  1  redirect in progress (state != IDLE)
ds_branch_err  output  1  sticky: control-transfer seen in a delay slot
branch_cnt  output  CNT_W  accepted control-transfer decisions
taken_cnt  output  CNT_W  accepted decisions that were taken

Behaviour:
- All outputs are registered. On reset_n=0 (asynchronous): state=IDLE; pc_src, flush_if, busy, ds_branch_err = 0; pc_target = 0; both counters = 0.
- Decision event: state==IDLE && !stall && (ID_branch_instr | jump_instr).
  - taken = jump_instr | (ID_branch_instr & branch_out).
  - If both ID_branch_instr and jump_instr are high, treat as a jump.
- Decision while stall=1: ignored. The instruction remains in ID and is re-evaluated with the current branch_out once the stall drops.
- FSM states: IDLE, REDIRECT.
  - IDLE -> REDIRECT on a taken decision; latch target_addr into pc_target.
  - A not-taken decision stays in IDLE and only updates the counters.
  - REDIRECT: pc_src=1, busy=1, flush_if = (DELAY_SLOT==0).
  - REDIRECT -> IDLE on the first cycle with stall=0. Redirect outputs stay asserted for 1 cycle when unstalled, or for 1+N cycles under N stall cycles.
- Latency: taken decision at edge k -> pc_src/pc_target valid in cycle k+1. In IDLE, pc_src=0 and flush_if=0.
- Decisions during REDIRECT are not accepted and not counted.
  - DELAY_SLOT=1: the ID instruction during REDIRECT is the delay slot. If ID_branch_instr|jump_instr is high there, set ds_branch_err=1 (sticky until reset).
  - DELAY_SLOT=0: the ID instruction is wrong-path, already being squashed. Ignore silently; no error.
- Counters:
  - branch_cnt += 1 per accepted decision; taken_cnt += 1 per taken accepted decision.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - taken_cnt <= branch_cnt always holds.
- Reset mid-REDIRECT returns to IDLE immediately and drops pc_src. The pending target is discarded.
- target_addr is sampled only on a decision edge. Changes at other times have no effect.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=1'b0, ST_REDIRECT=1'b1) and the default ADDR_W/CNT_W constants used by the PC and IF/ID stages.
- One natural sub-module: sat_counter (parameter W; inc and clear inputs; saturating count output), instantiated twice.
- FSM and output registers live in the top module.

Test Plan:
- Taken branch, no stall:
  - Stimulus: ID_branch_instr=1, branch_out=1, target_addr=0x0000_0040, DELAY_SLOT=1.
  - Response: next cycle pc_src=1, pc_target=0x40, flush_if=0 for exactly 1 cycle; branch_cnt=1, taken_cnt=1.
- Not-taken branch: ID_branch_instr=1, branch_out=0 -> pc_src stays 0, state IDLE; branch_cnt=1, taken_cnt=0.
- Stall interaction:
  - Stimulus: branch present with stall=1 for 2 cycles and branch_out toggling 0->1, then stall=0.
  - Response: decision taken from the unstalled cycle; redirect to target.
  - Follow-up: stall=1 for 3 cycles during REDIRECT -> pc_src held 4 cycles total.
- Delay-slot violation: DELAY_SLOT=1, taken jump followed by ID_branch_instr=1 in the REDIRECT cycle -> ds_branch_err=1 and stays 1; branch_cnt increments only once.
- DELAY_SLOT=0 squash: taken branch -> flush_if=1 with pc_src=1 for 1 cycle; a wrong-path branch in ID in that cycle is not counted and raises no error.
- Saturation and reset:
  - Preload via 2^CNT_W+3 taken branches (CNT_W=4 build) -> both counters stick at 15.
  - reset_n pulsed low mid-REDIRECT -> all outputs 0 asynchronously, before the next clk edge.
